// File: rtl/l2_flatten_pkg.sv
// Shared constants for the conv engine and the layer-2 flatten stage:
// memory bank selects, data/address widths and the flatten state encoding.
package l2_flatten_pkg;

    localparam int DW  = 20;
    localparam int AW  = 12;
    localparam int PIX = 1024;
    localparam int NW  = 11;

    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0    = 3'b001;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;
    localparam logic [2:0] CSEL_L2    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Even elements come from kernel 0, odd elements from kernel 1.
    function automatic logic [2:0] src_bank(input logic [NW-1:0] n);
        return n[0] ? CSEL_L1_K1 : CSEL_L1_K0;
    endfunction

endpackage

// File: rtl/l2_flatten.sv
// Flattens the two 32x32 pooled maps in MEM_L1 into MEM_L2, interleaving
// kernel-0 (even address) and kernel-1 (odd address) values per pixel.
module l2_flatten
    import l2_flatten_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam logic [NW-1:0] N_LAST = NW'(2 * PIX - 1);

    state_t        state, state_nx;
    logic [NW-1:0] n, n_nx;

    always_comb begin
        state_nx = state;
        n_nx     = n;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_READ;
                    n_nx     = '0;
                end
            end
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: begin
                if (n == N_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_READ;
                    n_nx     = n + 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with
    // the state they belong to; the read data is captured straight into
    // cdata_wr on the READ->WRITE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            n        <= '0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= CSEL_NONE;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
        end else begin
            state <= state_nx;
            n     <= n_nx;
            case (state_nx)
                ST_READ: begin
                    crd      <= 1'b1;
                    cwr      <= 1'b0;
                    csel     <= src_bank(n_nx);
                    caddr_rd <= {2'b00, n_nx[NW-1:1]};
                end
                ST_WRITE: begin
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= CSEL_L2;
                    caddr_wr <= {1'b0, n_nx};
                    cdata_wr <= cdata_rd;
                end
                default: begin
                    crd  <= 1'b0;
                    cwr  <= 1'b0;
                    csel <= CSEL_NONE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
